fpdiv_ctrl: RTL and testbench

FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

---
 rtl/fpdiv_pkg.sv | 35 +++
 rtl/fpdiv_iter_cnt.sv | 26 ++
 rtl/fpdiv_ctrl.sv | 135 +++++++++++++
 tb/tb_fpdiv_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and encodings for the Goldschmidt divider controller.
// State enum, mux select encodings, control bundle and default iteration count.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_D0   = 3'd1,
    S_N0   = 3'd2,
    S_NI   = 3'd3,
    S_DI   = 3'd4,
    S_FIN  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [1:0] MUX4_NUM  = 2'b00;
  localparam logic [1:0] MUX4_DEN  = 2'b01;
  localparam logic [1:0] MUX4_REGA = 2'b10;
  localparam logic [1:0] MUX4_REGB = 2'b11;

  localparam logic MUX2_K0   = 1'b0;
  localparam logic MUX2_REGC = 1'b1;

  localparam int ITER_DEFAULT = 3;

  typedef struct packed {
    logic       en_a;
    logic       en_b;
    logic       en_c;
    logic       sel_mux2;
    logic [1:0] sel_mux4;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = '0;

endpackage

// File: rtl/fpdiv_iter_cnt.sv
// 3-bit loadable down-counter for the Goldschmidt refinement loop.
// Ports: clk, reset (async active-low), load/val, dec; cnt and last (cnt<=1).
module fpdiv_iter_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] val,
  input  logic       dec,
  output logic [2:0] cnt,
  output logic       last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && (cnt != 3'd0)) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Terminal: this DI pass is the final refinement.
  assign last = (cnt <= 3'd1);

endmodule

// File: rtl/fpdiv_ctrl.sv
// Moore FSM sequencing a Goldschmidt divider datapath (K0 step + ITER passes).
// Ports: clk, reset (async active-low), start, a_in, b_in, rega_in -> num,
// denom, en_a/b/c, sel_mux2, sel_mux4, busy, done, quot.
// Optional abort input when FPDIV_CTRL_ABORT_EN is defined.
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FPDIV_CTRL_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [26:0] a_in,
  input  logic [26:0] b_in,
  input  logic [26:0] rega_in,
  output logic [26:0] num,
  output logic [26:0] denom,
  output logic        en_a,
  output logic        en_b,
  output logic        en_c,
  output logic        sel_mux2,
  output logic [1:0]  sel_mux4,
  output logic        busy,
  output logic        done,
  output logic [23:0] quot
);

  state_t     state;
  state_t     nxt;
  ctrl_t      ctl;
  logic       accept;
  logic       abort_hit;
  logic [2:0] cnt;
  logic       last;
  logic       unused_lsb;

  assign unused_lsb = ^rega_in[2:0];

`ifdef FPDIV_CTRL_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept = (state == S_IDLE) && start;

  fpdiv_iter_cnt u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .val   (3'(ITER)),
    .dec   (state == S_DI),
    .cnt   (cnt),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    ctl = CTRL_OFF;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = S_D0;
      end
      S_D0: begin
        ctl.sel_mux2 = MUX2_K0;
        ctl.sel_mux4 = MUX4_DEN;
        ctl.en_b     = 1'b1;
        ctl.en_c     = 1'b1;
        nxt          = S_N0;
      end
      S_N0: begin
        ctl.sel_mux2 = MUX2_K0;
        ctl.sel_mux4 = MUX4_NUM;
        ctl.en_a     = 1'b1;
        nxt          = S_NI;
      end
      // Numerator consumes regc before DI overwrites it.
      S_NI: begin
        ctl.sel_mux2 = MUX2_REGC;
        ctl.sel_mux4 = MUX4_REGA;
        ctl.en_a     = 1'b1;
        nxt          = S_DI;
      end
      S_DI: begin
        ctl.sel_mux2 = MUX2_REGC;
        ctl.sel_mux4 = MUX4_REGB;
        ctl.en_b     = 1'b1;
        ctl.en_c     = 1'b1;
        nxt          = last ? S_FIN : S_NI;
      end
      S_FIN:  nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort_hit) nxt = S_IDLE;
  end

  assign en_a     = ctl.en_a;
  assign en_b     = ctl.en_b;
  assign en_c     = ctl.en_c;
  assign sel_mux2 = ctl.sel_mux2;
  assign sel_mux4 = ctl.sel_mux4;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num   <= '0;
      denom <= '0;
    end else if (accept) begin
      num   <= a_in;
      denom <= b_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quot <= '0;
    end else if ((state == S_FIN) && !abort_hit) begin
      quot <= rega_in[26:3];
    end
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Self-checking bench for fpdiv_ctrl with a behavioural Goldschmidt datapath.
// Reference: phase derived from cycles since acceptance; quotient vs a/b.
module tb_fpdiv_ctrl;

  localparam int IT     = 3;
  localparam int FIN_K  = 3 + 2 * IT;
  localparam int DONE_K = 4 + 2 * IT;
`ifdef FPDIV_CTRL_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [26:0] a_in = '0;
  logic [26:0] b_in = '0;
  logic [26:0] rega_in;
  logic [26:0] num, denom;
  logic        en_a, en_b, en_c, sel_mux2;
  logic [1:0]  sel_mux4;
  logic        busy, done;
  logic [23:0] quot;

  logic [26:0] dp_rega = '0;
  logic [26:0] dp_regb = '0;
  logic [26:0] dp_regc = '0;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int cyc = 0;
  int dones = 0;
  int last_done = 0;
  logic [26:0] exp_num = '0;
  logic [26:0] exp_den = '0;
  logic [23:0] exp_quot = '0;

  assign rega_in = dp_rega;

  fpdiv_ctrl #(.ITER(IT)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef FPDIV_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .rega_in  (rega_in),
    .num      (num),
    .denom    (denom),
    .en_a     (en_a),
    .en_b     (en_b),
    .en_c     (en_c),
    .sel_mux2 (sel_mux2),
    .sel_mux4 (sel_mux4),
    .busy     (busy),
    .done     (done),
    .quot     (quot)
  );

  always #5 clk = ~clk;

  // Coarse reciprocal seed: 1/d with the low 12 fraction bits dropped.
  function automatic longint k0(input logic [26:0] d);
    longint r;
    if (d == 0) return 0;
    r = (longint'(1) << 44) / longint'(d);
    return r & ~longint'(12'hFFF);
  endfunction

  always @(posedge clk) begin
    longint x, f, p;
    case (sel_mux4)
      2'b00:   x = longint'(num);
      2'b01:   x = longint'(denom);
      2'b10:   x = longint'(dp_rega);
      default: x = longint'(dp_regb);
    endcase
    f = sel_mux2 ? longint'(dp_regc) : k0(denom);
    p = (x * f) >> 22;
    if (en_a) dp_rega <= 27'(p);
    if (en_b) dp_regb <= 27'(p);
    if (en_c) dp_regc <= 27'((longint'(1) << 23) - p);
  end

  // {busy, done, en_a, en_b, en_c, sel_mux2, sel_mux4} expected k cycles
  // after acceptance.
  function automatic logic [7:0] ctl_exp(input int kk);
    if (kk == 0)      return 8'b0000_0000;
    if (kk == 1)      return 8'b1001_1001;
    if (kk == 2)      return 8'b1010_0000;
    if (kk < FIN_K)   return ((kk - 3) % 2 == 0) ? 8'b1010_0110
                                                 : 8'b1001_1111;
    if (kk == FIN_K)  return 8'b1000_0000;
    return 8'b1100_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_near(input string tag, input longint obs,
                          input longint refv, input longint tol);
    longint d;
    d = obs - refv;
    if (d < 0) d = -d;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h tol=%0d", tag, obs, refv, tol);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ctl"}, 32'({busy, done, en_a, en_b, en_c, sel_mux2,
                            sel_mux4}), 32'(ctl_exp(k)));
    chk({tag, "_num"}, 32'(num), 32'(exp_num));
    chk({tag, "_den"}, 32'(denom), 32'(exp_den));
    chk({tag, "_quot"}, 32'(quot), 32'(exp_quot));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    cyc++;
    if (k == 0) begin
      if (start) begin
        k = 1;
        exp_num = a_in;
        exp_den = b_in;
      end
    end else if (ABORT_ON && abort) begin
      k = 0;
    end else if (k == DONE_K) begin
      k = 0;
    end else begin
      if (k == FIN_K) exp_quot = dp_rega[26:3];
      k++;
    end
    #1;
    if (done === 1'b1) begin
      dones++;
      last_done = cyc;
    end
    check_all(tag);
  endtask

  task automatic op(input logic [26:0] a, input logic [26:0] b,
                    input bit noise, input bit hold);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step("acc");
    for (int i = 0; i < DONE_K; i++) begin
      if (noise) begin
        start = 1'($urandom);
        a_in  = 27'($urandom);
        b_in  = 27'($urandom);
      end else if (hold) begin
        start = 1'b1;
        a_in  = 27'($urandom);
      end else begin
        start = 1'b0;
      end
      step("run");
    end
    start = 1'b0;
  endtask

  function automatic longint ref_q(input logic [26:0] a,
                                   input logic [26:0] b);
    return (longint'(a) << 19) / longint'(b);
  endfunction

  initial begin
    int d0, t0;
    logic [26:0] a, b;
    logic [23:0] q_before;

    #2;
    check_all("reset");
    repeat (2) step("rst_hold");
    reset = 1'b1;
    step("idle");

    op(27'h40_0000, 27'h40_0000, 1'b0, 1'b0);
    chk_near("q_one", longint'(quot), 64'h8_0000, 1);

    op(27'h60_0000, 27'h40_0000, 1'b0, 1'b0);
    chk_near("q_1p5", longint'(quot), 64'hC_0000, 1);

    d0 = dones;
    a  = 27'h51_2345;
    op(a, 27'h47_0000, 1'b0, 1'b1);
    chk("held_dones", 32'(dones - d0), 32'd1);
    chk("held_num", 32'(num), 32'(a));

    start = 1'b1;
    t0 = last_done;
    a_in = 27'h45_6789;
    b_in = 27'h5A_0000;
    step("b2b_acc");
    start = 1'b0;
    for (int i = 0; i < 30 && k != 0; i++) step("b2b_run");
    chk("b2b_gap", 32'(last_done - t0), 32'd11);

    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 3)) step("gap");
      a = 27'h40_0000 | 27'($urandom_range(0, 27'h3F_FFFF));
      b = 27'h40_0000 | 27'($urandom_range(0, 27'h3F_FFFF));
      op(a, b, 1'b1, 1'b0);
      chk_near("q_rand", longint'(quot), ref_q(a, b), 2);
    end

    a_in  = 27'h55_5555;
    b_in  = 27'h44_4444;
    start = 1'b1;
    step("rmid_acc");
    start = 1'b0;
    step("rmid_d0");
    step("rmid_n0");
    chk("rmid_in_ni", 32'(k), 32'd3);
    #2;
    reset = 1'b0;
    k = 0;
    exp_num = '0;
    exp_den = '0;
    exp_quot = '0;
    #1;
    check_all("rmid_async");
    step("rmid_low");
    reset = 1'b1;
    step("rmid_rel");
    op(27'h60_0000, 27'h40_0000, 1'b0, 1'b0);
    chk_near("q_after_rst", longint'(quot), 64'hC_0000, 1);

    if (ABORT_ON) begin
      q_before = exp_quot;
      d0 = dones;
      a_in  = 27'h70_0000;
      b_in  = 27'h40_0000;
      start = 1'b1;
      step("ab_acc");
      start = 1'b0;
      repeat (3) step("ab_run");
      abort = 1'b1;
      step("ab_hit");
      abort = 1'b0;
      chk("ab_idle", 32'(busy), 32'd0);
      repeat (12) step("ab_after");
      chk("ab_nodone", 32'(dones - d0), 32'd0);
      chk("ab_quot", 32'(quot), 32'(q_before));
      abort = 1'b1;
      op(27'h40_0000, 27'h40_0000, 1'b0, 1'b0);
      abort = 1'b0;
      chk("ab_idle_ign", 32'(dones - d0), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
